// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle processor control path:
// opcodes, sequencer states, ALU operations, PC sources, instruction classes.
package cpu_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_SLTI  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic is_rtype;
        logic is_imm;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_halt;
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to one-hot instruction class flags; ADDI and SLTI share is_imm.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: cls.is_rtype  = 1'b1;
            OP_ADDI:  cls.is_imm    = 1'b1;
            OP_SLTI:  cls.is_imm    = 1'b1;
            OP_LW:    cls.is_load   = 1'b1;
            OP_SW:    cls.is_store  = 1'b1;
            OP_BEQ:   cls.is_branch = 1'b1;
            OP_J:     cls.is_jump   = 1'b1;
            OP_HALT:  cls.is_halt   = 1'b1;
            default:  cls = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes.
// Define CTRL_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted,
    output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_e       state_q, state_d;
    instr_class_t cls;

    ctrl_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = PC_INC;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        state      = state_q;
        unique case (state_q)
            S_FETCH: begin
                imem_req = run;
                if (run && imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls.is_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    state_d  = S_FETCH;
                end else if (cls.is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    cls.is_rtype: begin
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    cls.is_imm: begin
                        alu_src_b = 1'b1;
                        alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                        state_d   = S_WB;
                    end
                    cls.is_load, cls.is_store: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_ADD;
                        state_d   = S_MEM;
                    end
                    cls.is_branch: begin
                        alu_op   = ALU_SUB;
                        pc_write = zero;
                        pc_src   = PC_BRANCH;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.is_store;
                if (dmem_ready) begin
                    state_d = cls.is_load ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.is_rtype;
                mem_to_reg = cls.is_load;
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Reset silences every output, including the debug state view.
        if (rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            pc_src     = PC_INC;
            alu_src_b  = 1'b0;
            alu_op     = ALU_ADD;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
            state      = 3'd0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;
    logic        retire;

    assign retire = (state_d == S_FETCH && state_q != S_FETCH) ||
                    (state_d == S_HALT && state_q != S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: stimulus pushes the
// hand-derived per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       halted;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
    } outv_t;

    //                                st  hl ir dr dw iw pw rw pcs  asb alu  rd m2r
    localparam outv_t F_IDLE = '{3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t F_WAIT = '{3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t F_GO   = '{3'd0, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t D_ANY  = '{3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t D_J    = '{3'd1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 0, 0};
    localparam outv_t E_R    = '{3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 0};
    localparam outv_t E_I    = '{3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0};
    localparam outv_t E_SLT  = '{3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 0, 0};
    localparam outv_t E_BQ1  = '{3'd2, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 2'b01, 0, 0};
    localparam outv_t E_BQ0  = '{3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b01, 0, 0};
    localparam outv_t M_LW   = '{3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t M_SW   = '{3'd3, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t W_R    = '{3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1, 0};
    localparam outv_t W_I    = '{3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0};
    localparam outv_t W_LW   = '{3'd4, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 1};
    localparam outv_t H_ST   = '{3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0};

    logic       clk = 1'b0;
    logic       rst, run, zero, imem_ready, dmem_ready;
    logic [2:0] opcode;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
    logic [1:0] pc_src, alu_op;
    logic       alu_src_b, reg_dst, mem_to_reg, halted;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    logic [31:0] ic_before;
`endif

    outv_t got;
    outv_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .state      (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    assign got = '{state, halted, imem_req, dmem_req, dmem_we, ir_write,
                   pc_write, reg_write, pc_src, alu_src_b, alu_op,
                   reg_dst, mem_to_reg};

    always @(negedge clk) begin
        outv_t e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s @%0t: got %h required %h", n, $time, got, e);
            end
        end
    end

    task automatic step(input logic r, input logic rn, input logic [2:0] op,
                        input logic z, input logic imr, input logic dmr,
                        input outv_t e, input string nm);
        rst        = r;
        run        = rn;
        opcode     = op;
        zero       = z;
        imem_ready = imr;
        dmem_ready = dmr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic check32(input string nm, input logic [31:0] a,
                           input logic [31:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, a, b);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 3'b000;
        zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        // reset with run and readies high: outputs must stay silent
        step(1, 1, 3'b000, 0, 1, 1, F_IDLE, "rst0");
        step(1, 1, 3'b000, 0, 1, 1, F_IDLE, "rst1");
        // R-type
        step(0, 1, 3'b000, 0, 1, 1, F_GO,   "r_fetch");
        step(0, 1, 3'b000, 0, 1, 1, D_ANY,  "r_dec");
        step(0, 1, 3'b000, 0, 1, 1, E_R,    "r_exec");
        step(0, 1, 3'b000, 0, 1, 1, W_R,    "r_wb");
        // ADDI
        step(0, 1, 3'b001, 0, 1, 1, F_GO,   "addi_fetch");
        step(0, 1, 3'b001, 0, 1, 1, D_ANY,  "addi_dec");
        step(0, 1, 3'b001, 0, 1, 1, E_I,    "addi_exec");
        step(0, 1, 3'b001, 0, 1, 1, W_I,    "addi_wb");
        // SLTI
        step(0, 1, 3'b110, 0, 1, 1, F_GO,   "slti_fetch");
        step(0, 1, 3'b110, 0, 1, 1, D_ANY,  "slti_dec");
        step(0, 1, 3'b110, 0, 1, 1, E_SLT,  "slti_exec");
        step(0, 1, 3'b110, 0, 1, 1, W_I,    "slti_wb");
        // LW with three data wait cycles: 8 cycles total
        step(0, 1, 3'b010, 0, 1, 0, F_GO,   "lw_fetch");
        step(0, 1, 3'b010, 0, 1, 0, D_ANY,  "lw_dec");
        step(0, 1, 3'b010, 0, 1, 0, E_I,    "lw_exec");
        step(0, 1, 3'b010, 0, 1, 0, M_LW,   "lw_mem_w0");
        step(0, 1, 3'b010, 0, 1, 0, M_LW,   "lw_mem_w1");
        step(0, 1, 3'b010, 0, 1, 0, M_LW,   "lw_mem_w2");
        step(0, 1, 3'b010, 0, 1, 1, M_LW,   "lw_mem_go");
        step(0, 1, 3'b010, 0, 1, 0, W_LW,   "lw_wb");
        // SW zero-wait
        step(0, 1, 3'b011, 0, 1, 1, F_GO,   "sw_fetch");
        step(0, 1, 3'b011, 0, 1, 1, D_ANY,  "sw_dec");
        step(0, 1, 3'b011, 0, 1, 1, E_I,    "sw_exec");
        step(0, 1, 3'b011, 0, 1, 1, M_SW,   "sw_mem");
        // instruction-fetch waits, then BEQ taken and not taken
        step(0, 1, 3'b100, 1, 0, 1, F_WAIT, "if_wait0");
        step(0, 1, 3'b100, 1, 0, 1, F_WAIT, "if_wait1");
        step(0, 1, 3'b100, 1, 1, 1, F_GO,   "beq1_fetch");
        step(0, 1, 3'b100, 1, 1, 1, D_ANY,  "beq1_dec");
        step(0, 1, 3'b100, 1, 1, 1, E_BQ1,  "beq1_exec");
        step(0, 1, 3'b100, 0, 1, 1, F_GO,   "beq0_fetch");
        step(0, 1, 3'b100, 0, 1, 1, D_ANY,  "beq0_dec");
        step(0, 1, 3'b100, 0, 1, 1, E_BQ0,  "beq0_exec");
        // imem_ready with run low is ignored
        step(0, 0, 3'b001, 0, 1, 1, F_IDLE, "ready_ignored");
        // run dropped during EXEC of ADDI
`ifdef CTRL_PERF_CNT_EN
        ic_before = instr_cnt;
`endif
        step(0, 1, 3'b001, 0, 1, 1, F_GO,   "drop_fetch");
        step(0, 1, 3'b001, 0, 1, 1, D_ANY,  "drop_dec");
        step(0, 0, 3'b001, 0, 1, 1, E_I,    "drop_exec");
        step(0, 0, 3'b001, 0, 1, 1, W_I,    "drop_wb");
        step(0, 0, 3'b001, 0, 1, 1, F_IDLE, "drop_idle0");
        step(0, 0, 3'b001, 0, 1, 1, F_IDLE, "drop_idle1");
`ifdef CTRL_PERF_CNT_EN
        check32("drop_instr_delta", instr_cnt - ic_before, 32'd1);
`endif
        // rst during a SW data wait
        step(0, 1, 3'b011, 0, 1, 0, F_GO,   "swr_fetch");
        step(0, 1, 3'b011, 0, 1, 0, D_ANY,  "swr_dec");
        step(0, 1, 3'b011, 0, 1, 0, E_I,    "swr_exec");
        step(0, 1, 3'b011, 0, 1, 0, M_SW,   "swr_mem_w0");
        step(0, 1, 3'b011, 0, 1, 0, M_SW,   "swr_mem_w1");
        step(1, 1, 3'b011, 0, 1, 0, F_IDLE, "swr_rst");
        step(0, 0, 3'b011, 0, 1, 0, F_IDLE, "swr_after");
`ifdef CTRL_PERF_CNT_EN
        step(1, 0, 3'b011, 0, 1, 0, F_IDLE, "swr_rst2");
        check32("rst_cycle_cnt", cycle_cnt, 32'd0);
        check32("rst_instr_cnt", instr_cnt, 32'd0);
`endif
        // J then HALT
        step(0, 1, 3'b101, 0, 1, 1, F_GO,   "j_fetch");
        step(0, 1, 3'b101, 0, 1, 1, D_J,    "j_dec");
        step(0, 1, 3'b111, 0, 1, 1, F_GO,   "halt_fetch");
        step(0, 1, 3'b111, 0, 1, 1, D_ANY,  "halt_dec");
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 3'b111, 1, 1, 1, H_ST, $sformatf("halt_%0d", i));
        end
        step(1, 1, 3'b111, 0, 1, 1, F_IDLE, "halt_rst");
        step(0, 0, 3'b000, 0, 1, 1, F_IDLE, "halt_after");
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
